// File: rtl/fifo_ctrl_fsm_if.sv
// Bundle between the FIFO controller and its environment: button/streaming
// requests toward the controller, enables/pointers/flags back out.
interface fifo_ctrl_fsm_if #(
  parameter int ADDR_W = 3
);
  logic              button;
  logic              mode;
  logic              wr_req;
  logic              rd_req;
  logic [ADDR_W:0]   Write_Ptr;
  logic [ADDR_W:0]   Read_Ptr;
  logic              Wen;
  logic              Ren;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output button, mode, wr_req, rd_req,
    input  Write_Ptr, Read_Ptr, Wen, Ren, fifo_full, fifo_empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  button, mode, wr_req, rd_req,
    output Write_Ptr, Read_Ptr, Wen, Ren, fifo_full, fifo_empty,
    output almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_fsm.sv
// FIFO pointer/flag controller driven by a one-shot button FSM and a streaming
// request path. Define FIFO_CTRL_ERR_FLAGS_EN to build sticky overflow/underflow.
module fifo_ctrl_fsm #(
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic            clk,
  input  logic            reset,
  fifo_ctrl_fsm_if.slave  bus
);

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_THR   = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_THR   = AE_LEVEL[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_MODE = 2'd1,
    READ_MODE  = 2'd2,
    HOLD       = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   write_ptr;
  logic [ADDR_W:0]   read_ptr;
  logic [ADDR_W:0]   occupancy;
  logic              full;
  logic              empty;
  logic              wen;
  logic              ren;
  logic              ovf_set;
  logic              unf_set;

  // Flags are derived only from registered pointers, never from requests.
  assign occupancy = write_ptr - read_ptr;
  assign empty     = (write_ptr == read_ptr);
  assign full      = (write_ptr[ADDR_W] != read_ptr[ADDR_W]) &&
                     (write_ptr[ADDR_W-1:0] == read_ptr[ADDR_W-1:0]);

  always_comb begin
    wen     = 1'b0;
    ren     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (state)
      IDLE: begin
        // A read in the same cycle frees the slot a full FIFO would refuse.
        ren     = bus.rd_req & ~empty;
        wen     = bus.wr_req & (~full | bus.rd_req);
        ovf_set = bus.wr_req & full & ~bus.rd_req;
        unf_set = bus.rd_req & empty;
      end
      WRITE_MODE: begin
        wen     = ~full;
        ovf_set = full;
      end
      READ_MODE: begin
        ren     = ~empty;
        unf_set = empty;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      write_ptr <= '0;
      read_ptr  <= '0;
    end else begin
      if (wen) write_ptr <= write_ptr + PTR_ONE;
      if (ren) read_ptr  <= read_ptr + PTR_ONE;
      case (state)
        IDLE: begin
          if (!bus.button) state <= bus.mode ? WRITE_MODE : READ_MODE;
        end
        WRITE_MODE: state <= HOLD;
        READ_MODE:  state <= HOLD;
        HOLD: begin
          if (bus.button) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (ovf_set) overflow_reg  <= 1'b1;
      if (unf_set) underflow_reg <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
`else
  logic unused_err;
  assign unused_err    = ovf_set ^ unf_set;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  // Strobes are gated by reset so nothing reaches storage while it is held.
  assign bus.Wen          = wen & reset;
  assign bus.Ren          = ren & reset;
  assign bus.Write_Ptr    = write_ptr;
  assign bus.Read_Ptr     = read_ptr;
  assign bus.count        = occupancy;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (occupancy >= AF_THR);
  assign bus.almost_empty = (occupancy <= AE_THR);

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Directed bench for fifo_ctrl_fsm (ADDR_W=3, AF=6, AE=2); expected error
// flags follow FIFO_CTRL_ERR_FLAGS_EN.
module tb_fifo_ctrl_fsm;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   passed;

  fifo_ctrl_fsm_if #(.ADDR_W(3)) bus ();

  fifo_ctrl_fsm #(.ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.button = 1'b1;
    bus.mode   = 1'b0;
    reset      = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    bus.button = 1'b1;
    bus.mode   = 1'b1;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    tick();
    total++;
    if ({bus.Wen, bus.Ren} !== 2'b00)
      $display("FAIL reset_strobes got=%b exp=00", {bus.Wen, bus.Ren});
    else passed++;
    total++;
    if ({bus.Write_Ptr, bus.Read_Ptr, bus.count} !== 12'h000)
      $display("FAIL reset_ptrs wp=%0d rp=%0d cnt=%0d exp=0", bus.Write_Ptr, bus.Read_Ptr, bus.count);
    else passed++;
    total++;
    if ({bus.fifo_empty, bus.fifo_full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow} !== 6'b101000)
      $display("FAIL reset_flags got=%b exp=101000",
               {bus.fifo_empty, bus.fifo_full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow});
    else passed++;
    $display("reset: wp=%0d rp=%0d empty=%b", bus.Write_Ptr, bus.Read_Ptr, bus.fifo_empty);
    do_reset();
  endtask

  task automatic test_fill;
    do_reset();
    bus.wr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (bus.Wen !== 1'b1) $display("FAIL fill_wen i=%0d got=%b exp=1", i, bus.Wen);
      else passed++;
      tick();
      total++;
      if (bus.count !== 4'(i + 1) || bus.almost_full !== ((i + 1) >= 6) ||
          bus.almost_empty !== ((i + 1) <= 2) || bus.fifo_full !== (i == 7))
        $display("FAIL fill_flags i=%0d cnt=%0d af=%b ae=%b full=%b exp cnt=%0d",
                 i, bus.count, bus.almost_full, bus.almost_empty, bus.fifo_full, i + 1);
      else passed++;
      $display("fill write %0d: count=%0d af=%b full=%b", i, bus.count, bus.almost_full, bus.fifo_full);
    end
    total++;
    if (bus.Write_Ptr !== 4'b1000) $display("FAIL fill_wptr got=%b exp=1000", bus.Write_Ptr);
    else passed++;
    #1;
    total++;
    if (bus.Wen !== 1'b0) $display("FAIL full_refuse_wen got=%b exp=0", bus.Wen);
    else passed++;
    tick();
    bus.wr_req = 1'b0;
    total++;
    if (bus.overflow !== ERR || bus.count !== 4'd8)
      $display("FAIL full_overflow ovf=%b cnt=%0d exp ovf=%b cnt=8", bus.overflow, bus.count, ERR);
    else passed++;
    $display("9th write refused: overflow=%b count=%0d", bus.overflow, bus.count);
  endtask

  task automatic test_full_rw;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    total++;
    if ({bus.Wen, bus.Ren} !== 2'b11) $display("FAIL full_rw_strobes got=%b exp=11", {bus.Wen, bus.Ren});
    else passed++;
    tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    total++;
    if (bus.count !== 4'd8 || bus.Read_Ptr !== 4'd1 || bus.Write_Ptr !== 4'd9)
      $display("FAIL full_rw_ptrs cnt=%0d rp=%0d wp=%0d exp 8/1/9", bus.count, bus.Read_Ptr, bus.Write_Ptr);
    else passed++;
    $display("full rw: count=%0d rp=%0d wp=%0d", bus.count, bus.Read_Ptr, bus.Write_Ptr);
  endtask

  task automatic test_empty_rw;
    do_reset();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    total++;
    if ({bus.Wen, bus.Ren} !== 2'b10) $display("FAIL empty_rw_strobes got=%b exp=10", {bus.Wen, bus.Ren});
    else passed++;
    tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    total++;
    if (bus.count !== 4'd1 || bus.underflow !== ERR || bus.overflow !== 1'b0)
      $display("FAIL empty_rw_result cnt=%0d unf=%b ovf=%b exp cnt=1 unf=%b ovf=0",
               bus.count, bus.underflow, bus.overflow, ERR);
    else passed++;
    $display("empty rw: count=%0d underflow=%b", bus.count, bus.underflow);
  endtask

  task automatic test_button_read_empty;
    do_reset();
    bus.mode   = 1'b0;
    bus.button = 1'b0;
    tick();
    #1;
    total++;
    if (bus.Ren !== 1'b0) $display("FAIL btn_read_ren got=%b exp=0", bus.Ren);
    else passed++;
    tick();
    total++;
    if (bus.underflow !== ERR) $display("FAIL btn_read_underflow got=%b exp=%b", bus.underflow, ERR);
    else passed++;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({bus.Wen, bus.Ren} !== 2'b00) $display("FAIL hold_strobes cyc=%0d got=%b exp=00", i, {bus.Wen, bus.Ren});
      else passed++;
      tick();
    end
    bus.wr_req = 1'b0;
    bus.button = 1'b1;
    tick();
    bus.wr_req = 1'b1;
    #1;
    total++;
    if (bus.Wen !== 1'b1) $display("FAIL release_idle_wen got=%b exp=1", bus.Wen);
    else passed++;
    tick();
    bus.wr_req = 1'b0;
    total++;
    if (bus.count !== 4'd1 || bus.Read_Ptr !== 4'd0)
      $display("FAIL btn_read_count cnt=%0d rp=%0d exp 1/0", bus.count, bus.Read_Ptr);
    else passed++;
    $display("button read on empty: underflow=%b count=%0d", bus.underflow, bus.count);
  endtask

  task automatic test_button_write;
    int pulses;
    do_reset();
    pulses     = 0;
    bus.mode   = 1'b1;
    bus.button = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.Wen === 1'b1) pulses++;
    end
    bus.button = 1'b1;
    tick();
    if (bus.Wen === 1'b1) pulses++;
    tick();
    total++;
    if (pulses !== 1 || bus.count !== 4'd1)
      $display("FAIL btn_write_once pulses=%0d cnt=%0d exp 1/1", pulses, bus.count);
    else passed++;
    bus.button = 1'b0;
    tick();
    tick();
    bus.button = 1'b1;
    tick();
    total++;
    if (bus.count !== 4'd2 || bus.Write_Ptr !== 4'd2)
      $display("FAIL btn_write_second cnt=%0d wp=%0d exp 2/2", bus.count, bus.Write_Ptr);
    else passed++;
    $display("button writes: pulses=%0d count=%0d", pulses, bus.count);
  endtask

  task automatic test_interleave;
    logic [3:0] wp;
    logic [3:0] rp;
    do_reset();
    wp = 4'd0;
    rp = 4'd0;
    for (int i = 0; i < 40; i++) begin
      bus.wr_req = (i % 2 == 0);
      bus.rd_req = (i % 2 == 1);
      #1;
      total++;
      if (bus.fifo_empty !== (wp == rp) || bus.Write_Ptr !== wp || bus.Read_Ptr !== rp)
        $display("FAIL interleave cyc=%0d empty=%b wp=%0d rp=%0d exp empty=%b wp=%0d rp=%0d",
                 i, bus.fifo_empty, bus.Write_Ptr, bus.Read_Ptr, (wp == rp), wp, rp);
      else passed++;
      tick();
      if (i % 2 == 0) wp = wp + 4'd1;
      else rp = rp + 4'd1;
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    total++;
    if (bus.Write_Ptr !== 4'd4 || bus.Read_Ptr !== 4'd4 || bus.fifo_empty !== 1'b1 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL interleave_end wp=%0d rp=%0d empty=%b ovf=%b unf=%b exp 4/4/1/0/0",
               bus.Write_Ptr, bus.Read_Ptr, bus.fifo_empty, bus.overflow, bus.underflow);
    else passed++;
    $display("interleave: wp=%0d rp=%0d", bus.Write_Ptr, bus.Read_Ptr);
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.wr_req = 1'b1;
    repeat (5) tick();
    total++;
    if (bus.count !== 4'd5) $display("FAIL mid_count got=%0d exp=5", bus.count);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (bus.Write_Ptr !== 4'd0 || bus.count !== 4'd0 || bus.fifo_empty !== 1'b1 ||
        bus.Wen !== 1'b0 || bus.almost_empty !== 1'b1)
      $display("FAIL mid_async wp=%0d cnt=%0d empty=%b wen=%b ae=%b exp 0/0/1/0/1",
               bus.Write_Ptr, bus.count, bus.fifo_empty, bus.Wen, bus.almost_empty);
    else passed++;
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (bus.Wen !== 1'b1 || bus.Write_Ptr !== 4'd0)
      $display("FAIL post_reset_write wen=%b wp=%0d exp 1/0", bus.Wen, bus.Write_Ptr);
    else passed++;
    tick();
    bus.wr_req = 1'b0;
    total++;
    if (bus.Write_Ptr !== 4'd1 || bus.count !== 4'd1)
      $display("FAIL post_reset_ptr wp=%0d cnt=%0d exp 1/1", bus.Write_Ptr, bus.count);
    else passed++;
    $display("mid reset: wp=%0d count=%0d", bus.Write_Ptr, bus.count);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_button_read_empty();
    test_button_write();
    test_interleave();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
